// File: rtl/pulse_event_queue_if.sv
// Event handshake between the pulse event queue and the DFX command sequencer.
interface pulse_event_queue_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic             ev_valid;
    logic [IDX_W-1:0] ev_lane;
    logic             ev_ready;

    modport master (
        output ev_valid,
        output ev_lane,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_lane,
        output ev_ready
    );
endinterface

// File: rtl/pulse_event_queue.sv
// Per-lane saturating pulse counters drained one event at a time, round-robin,
// through a registered valid/ready output stage.
module pulse_event_queue #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     pulse_in,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     ovf_clr,
    output logic [WIDTH-1:0]     pending,
    output logic [WIDTH-1:0]     ovf,
    pulse_event_queue_if.master  ev
);
    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned SUM_W = IDX_W + 1;

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] lane_q, lane_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] ovf_q, ovf_d;

    logic             load;
    logic             found;
    logic             do_grant;
    logic [IDX_W-1:0] grant;
    logic [SUM_W-1:0] lane_sum;
    logic [IDX_W-1:0] cand;
    logic             inc;
    logic             dec;

    // State, output, pointer, counter and overflow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            lane_q   <= '0;
            rr_ptr_q <= '0;
            ovf_q    <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            rr_ptr_q <= rr_ptr_d;
            ovf_q    <= ovf_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Round-robin grant, output-stage next state and counter updates
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        rr_ptr_d = rr_ptr_q;
        ovf_d    = ovf_q & ~ovf_clr;
        found    = 1'b0;
        grant    = '0;
        lane_sum = '0;
        cand     = '0;
        inc      = 1'b0;
        dec      = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        // The output register can take a new event when empty or being accepted
        load = (state_q == EMPTY) || ev.ev_ready;

        // First non-empty lane starting at the round-robin pointer
        for (int unsigned k = 0; k < WIDTH; k++) begin
            lane_sum = {1'b0, rr_ptr_q} + SUM_W'(k);
            if (lane_sum >= SUM_W'(WIDTH)) begin
                lane_sum = lane_sum - SUM_W'(WIDTH);
            end
            cand = IDX_W'(lane_sum);
            if (!found && (cnt_q[cand] != '0)) begin
                found = 1'b1;
                grant = cand;
            end
        end

        // Flush blocks new grants but lets the held event drain normally
        do_grant = load && found && !flush;

        case (state_q)
            EMPTY: begin
                if (do_grant) begin
                    state_d = HOLD;
                    lane_d  = grant;
                end
            end
            HOLD: begin
                if (do_grant) begin
                    lane_d = grant;
                end else if (ev.ev_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (flush) begin
            rr_ptr_d = '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_d[i] = '0;
            end
        end else begin
            if (do_grant) begin
                rr_ptr_d = (grant == LAST_IDX) ? '0 : grant + IDX_W'(1);
            end
            for (int unsigned i = 0; i < WIDTH; i++) begin
                inc = pulse_in[i];
                dec = do_grant && (grant == IDX_W'(i));
                if (inc && !dec) begin
                    if (cnt_q[i] == CNT_MAX) begin
                        ovf_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end else if (dec && !inc) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    // Pending flags straight from the registered counters
    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pending[i] = (cnt_q[i] != '0);
        end
    end

    assign ovf         = ovf_q;
    assign ev.ev_valid = state_q;
    assign ev.ev_lane  = lane_q;
endmodule

// File: tb/tb_pulse_event_queue.sv
// Directed bench for pulse_event_queue with a lane-order scoreboard.
module tb_pulse_event_queue;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] pulse_in;
    logic             flush;
    logic [WIDTH-1:0] ovf_clr;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] ovf;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_q[$];

    pulse_event_queue_if #(.WIDTH(WIDTH)) evif ();

    pulse_event_queue #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pulse_in (pulse_in),
        .flush    (flush),
        .ovf_clr  (ovf_clr),
        .pending  (pending),
        .ovf      (ovf),
        .ev       (evif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every handshake pops the next expected lane
    always @(negedge clk) begin
        if (rst_n && evif.ev_valid && evif.ev_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_event", 32'(evif.ev_lane), 32'hFFFF);
            end else begin
                chk("sb_lane", 32'(evif.ev_lane), 32'(exp_q.pop_front()));
            end
        end
    end

    // Hard stop so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        pulse_in      = '0;
        flush         = 1'b0;
        ovf_clr       = '0;
        evif.ev_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_valid",   32'(evif.ev_valid), 32'd0);
        chk("rst_lane",    32'(evif.ev_lane),  32'd0);
        chk("rst_pending", 32'(pending),       32'd0);
        chk("rst_ovf",     32'(ovf),           32'd0);

        // Single pulse latency
        pulse_in = 4'b0100;
        exp_q.push_back(2);
        tick();
        pulse_in = '0;
        chk("t1_valid_n1",   32'(evif.ev_valid), 32'd0);
        chk("t1_pending_n1", 32'(pending),       32'b0100);
        tick();
        chk("t1_valid_n2",   32'(evif.ev_valid), 32'd1);
        chk("t1_lane_n2",    32'(evif.ev_lane),  32'd2);
        chk("t1_pending_n2", 32'(pending),       32'd0);
        tick();
        chk("t1_valid_n3",   32'(evif.ev_valid), 32'd0);

        // Flush to bring the round-robin pointer back to 0
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Round-robin over three lanes, one per cycle
        pulse_in = 4'b1011;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(3);
        tick();
        pulse_in = '0;
        tick();
        chk("t2_valid_a", 32'(evif.ev_valid), 32'd1);
        chk("t2_lane_a",  32'(evif.ev_lane),  32'd0);
        tick();
        chk("t2_valid_b", 32'(evif.ev_valid), 32'd1);
        chk("t2_lane_b",  32'(evif.ev_lane),  32'd1);
        tick();
        chk("t2_valid_c", 32'(evif.ev_valid), 32'd1);
        chk("t2_lane_c",  32'(evif.ev_lane),  32'd3);
        tick();
        chk("t2_valid_d", 32'(evif.ev_valid), 32'd0);

        // Pointer back at 0: lane 1 must come before lane 3
        pulse_in = 4'b1010;
        exp_q.push_back(1);
        exp_q.push_back(3);
        tick();
        pulse_in = '0;
        tick();
        chk("t2_rr_first",  32'(evif.ev_lane), 32'd1);
        tick();
        chk("t2_rr_second", 32'(evif.ev_lane), 32'd3);
        tick();
        chk("t2_rr_idle",   32'(evif.ev_valid), 32'd0);

        // Backpressure: held event stays stable while lane 0 accumulates
        evif.ev_ready = 1'b0;
        pulse_in = 4'b0100;
        exp_q.push_back(2);
        tick();
        pulse_in = '0;
        tick();
        chk("t3_presented", 32'(evif.ev_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            pulse_in = (i < 5) ? 4'b0001 : 4'b0000;
            tick();
            chk("t3_hold_valid", 32'(evif.ev_valid), 32'd1);
            chk("t3_hold_lane",  32'(evif.ev_lane),  32'd2);
        end
        pulse_in = '0;
        chk("t3_pending", 32'(pending), 32'b0001);
        for (int i = 0; i < 5; i++) exp_q.push_back(0);
        evif.ev_ready = 1'b1;
        repeat (7) tick();
        chk("t3_drained", 32'(evif.ev_valid), 32'd0);
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Saturation: 17 pulses on lane 1 under backpressure
        evif.ev_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            pulse_in = 4'b0010;
            tick();
            if (i == 15) chk("t4_ovf_before", 32'(ovf), 32'd0);
        end
        pulse_in = '0;
        chk("t4_ovf_set",  32'(ovf),            32'b0010);
        chk("t4_pending",  32'(pending),        32'b0010);
        chk("t4_valid",    32'(evif.ev_valid),  32'd1);
        chk("t4_lane",     32'(evif.ev_lane),   32'd1);
        for (int i = 0; i < 16; i++) exp_q.push_back(1);
        evif.ev_ready = 1'b1;
        repeat (18) tick();
        chk("t4_drained",   32'(evif.ev_valid), 32'd0);
        chk("t4_sb_empty",  32'(exp_q.size()),  32'd0);
        chk("t4_ovf_stick", 32'(ovf),           32'b0010);
        ovf_clr = 4'b0010;
        tick();
        ovf_clr = '0;
        chk("t4_ovf_clr",   32'(ovf),           32'd0);

        // Flush with cnt={3,0,2,0} and an event held
        evif.ev_ready = 1'b0;
        pulse_in = 4'b1000; tick();
        pulse_in = 4'b1010; tick();
        pulse_in = 4'b1010; tick();
        pulse_in = 4'b1000; tick();
        pulse_in = '0;
        chk("t5_pre_pending", 32'(pending),       32'b1010);
        chk("t5_pre_lane",    32'(evif.ev_lane),  32'd3);
        flush = 1'b1;
        pulse_in = 4'b0001;
        tick();
        flush = 1'b0;
        pulse_in = '0;
        chk("t5_flush_pending", 32'(pending),       32'd0);
        chk("t5_flush_valid",   32'(evif.ev_valid), 32'd1);
        chk("t5_flush_lane",    32'(evif.ev_lane),  32'd3);
        exp_q.push_back(3);
        evif.ev_ready = 1'b1;
        tick();
        chk("t5_after_valid", 32'(evif.ev_valid), 32'd0);
        repeat (3) tick();
        chk("t5_idle_valid",   32'(evif.ev_valid), 32'd0);
        chk("t5_idle_pending", 32'(pending),       32'd0);
        chk("t5_ovf_kept",     32'(ovf),           32'd0);

        // Asynchronous reset while holding with counters and overflow set
        evif.ev_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            pulse_in = 4'b0001;
            tick();
        end
        pulse_in = '0;
        chk("t6_pre_valid", 32'(evif.ev_valid), 32'd1);
        chk("t6_pre_ovf",   32'(ovf),           32'b0001);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid",   32'(evif.ev_valid), 32'd0);
        chk("t6_rst_pending", 32'(pending),       32'd0);
        chk("t6_rst_ovf",     32'(ovf),           32'd0);
        chk("t6_rst_lane",    32'(evif.ev_lane),  32'd0);
        tick();
        rst_n = 1'b1;
        evif.ev_ready = 1'b1;
        tick();

        // First pulse after reset behaves like a fresh start
        pulse_in = 4'b0100;
        exp_q.push_back(2);
        tick();
        pulse_in = '0;
        chk("t6_post_valid_n1", 32'(evif.ev_valid), 32'd0);
        tick();
        chk("t6_post_valid_n2", 32'(evif.ev_valid), 32'd1);
        chk("t6_post_lane_n2",  32'(evif.ev_lane),  32'd2);
        tick();
        chk("t6_post_valid_n3", 32'(evif.ev_valid), 32'd0);
        chk("final_sb_empty",   32'(exp_q.size()),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
